// File: rtl/match_search_ctrl_if.sv
// rtl/match_search_ctrl_if.sv - host-side bundle for the match search sequencer
// Host drives table writes and search requests; the sequencer returns status and results.
interface match_search_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 3
);
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             clr;
  logic             start;
  logic [WIDTH-1:0] key;
  logic             busy;
  logic             done;
  logic             hit;
  logic [IDX_W-1:0] hit_index;

  modport master (
    output wr_en, wr_addr, wr_data, clr, start, key,
    input  busy, done, hit, hit_index
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, clr, start, key,
    output busy, done, hit, hit_index
  );
endinterface

// File: rtl/match_search_ctrl.sv
// rtl/match_search_ctrl.sv - sequential first-match search over a register table
// One shared comparator walks the table one entry per clock against a latched key.
module match_search_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  match_search_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] key_q;
  logic [WIDTH-1:0] tbl [DEPTH];
  logic [DEPTH-1:0] vld;
  logic             busy_q;
  logic             done_q;
  logic             hit_q;
  logic [IDX_W-1:0] hit_idx_q;
  logic             match;
  logic             last;

  // Compare sees the table as it stood before this edge's write/clear.
  assign match = vld[idx] && (tbl[idx] == key_q);
  assign last  = (idx == IDX_W'(DEPTH - 1));

  // A same-cycle write overrides the clear for its own entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
      vld <= '0;
    end else begin
      if (bus.clr) vld <= '0;
      if (bus.wr_en) begin
        tbl[bus.wr_addr] <= bus.wr_data;
        vld[bus.wr_addr] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      key_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            key_q  <= bus.key;
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (match) begin
            hit_q     <= 1'b1;
            hit_idx_q <= idx;
            done_q    <= 1'b1;
            state     <= DONE;
          end else if (last) begin
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
            done_q    <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.hit       = hit_q;
  assign bus.hit_index = hit_idx_q;

endmodule
